clkrstgen: RTL and testbench

Parametrised clock-and-reset generator for the FPGA board wrappers, replacing the fixed divide-by-4 clock generator. Divides the board oscillator by a runtime-selectable integer, provides a rising-edge strobe in the oscillator domain, and produces a stretched system reset whose release is aligned to a divided-clock falling edge. It sits between the board pins (oscillator, reset button) and the `system` instance.

---
 rtl/clkrstgen.sv | 160 ++++++++++++++++
 tb/tb_clkrstgen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkrstgen.sv
// clkrstgen: board clock-and-reset generator.
//   Divides the board oscillator CLK by a runtime-selectable integer.
//   Provides a one-CLK rising-edge strobe for the divided clock.
//   Produces a system reset whose release coincides with a divided-clock falling edge.
//
// Build option: define CLKRSTGEN_STRETCH_EN to hold reset for RSTCYCLES
//   divided-clock rises after release. Without it, reset drops at the first
//   divided-clock fall after release, and RSTCYCLES is unused.
//
// Ports:
//   CLK             in   board oscillator, all flops on posedge
//   power_on_reset  in   asynchronous active-high reset
//   div             in   requested divisor (0 and 1 are clamped to 2)
//   div_load        in   one-CLK pulse that captures div as the pending divisor
//   clk             out  divided clock (registered)
//   clk_rise        out  one-CLK strobe, set on the CLK edge where clk rises
//   reset           out  system reset, active-high
//   cur_div         out  divisor of the current clk period
module clkrstgen #(
  parameter int unsigned DIVBITS     = 4,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned RSTCYCLES   = 16
) (
  input  logic               CLK,
  input  logic               power_on_reset,
  input  logic [DIVBITS-1:0] div,
  input  logic               div_load,
  output logic               clk,
  output logic               clk_rise,
  output logic               reset,
  output logic [DIVBITS-1:0] cur_div
);

  localparam int unsigned HW = DIVBITS + 1;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_COUNT,
    ST_ALIGN,
    ST_RUN
  } state_t;

  state_t             r_state;
  logic [DIVBITS-1:0] r_cnt;
  logic [DIVBITS-1:0] r_cur_div;
  logic [DIVBITS-1:0] r_pend;
  logic               r_clk;
  logic               r_clk_rise;
  logic               r_reset;

  logic               w_run;
  logic               w_wrap;
  logic               w_rise;
  logic [DIVBITS-1:0] w_cnt_inc;
  logic [DIVBITS-1:0] w_half;
  logic [DIVBITS-1:0] w_div_clamped;

  // The phase counter holds during the first edge after release, which is ASSERT -> next state.
  assign w_run         = (r_state != ST_ASSERT);
  assign w_cnt_inc     = r_cnt + DIVBITS'(1);
  assign w_wrap        = w_run && (w_cnt_inc == r_cur_div);
  // ceil(d/2) is computed one bit wider, so d = 2^DIVBITS-1 cannot overflow.
  assign w_half        = DIVBITS'((HW'(r_cur_div) + HW'(1)) >> 1);
  // Because d >= 2, the rise point never equals the wrap point.
  assign w_rise        = w_run && !w_wrap && (w_cnt_inc == w_half);
  assign w_div_clamped = (div < DIVBITS'(2)) ? DIVBITS'(2) : div;

  // Phase counter, divided clock, strobe and divisor pipeline.
  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_clk_rise <= 1'b0;
      r_cur_div  <= DIVBITS'(DEFAULT_DIV);
      r_pend     <= DIVBITS'(DEFAULT_DIV);
    end else begin
      r_clk_rise <= w_rise;
      if (div_load) begin
        r_pend <= w_div_clamped;
      end
      if (w_wrap) begin
        // The wrap takes the pending value from before this edge.
        // A load on this same edge therefore waits for the next wrap.
        r_cnt     <= '0;
        r_clk     <= 1'b0;
        r_cur_div <= r_pend;
      end else if (w_run) begin
        r_cnt <= w_cnt_inc;
        if (w_rise) begin
          r_clk <= 1'b1;
        end
      end
    end
  end

`ifdef CLKRSTGEN_STRETCH_EN
  localparam int unsigned RCW = $clog2(RSTCYCLES + 1);
  logic [RCW-1:0] r_rcnt;

  // Reset sequencer: stretch over RSTCYCLES divided rises, then align to a fall.
  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_state <= ST_ASSERT;
      r_reset <= 1'b1;
      r_rcnt  <= '0;
    end else begin
      case (r_state)
        ST_ASSERT: r_state <= ST_COUNT;
        ST_COUNT: begin
          if (w_rise) begin
            if (r_rcnt == RCW'(RSTCYCLES - 1)) begin
              r_state <= ST_ALIGN;
            end else begin
              r_rcnt <= r_rcnt + RCW'(1);
            end
          end
        end
        ST_ALIGN: begin
          if (w_wrap) begin
            r_state <= ST_RUN;
            r_reset <= 1'b0;
          end
        end
        ST_RUN:  r_reset <= 1'b0;
        default: r_state <= ST_ASSERT;
      endcase
    end
  end
`else
  logic w_unused_rstcycles;
  assign w_unused_rstcycles = (RSTCYCLES != 0);

  // Reset sequencer without stretch: release at the first divided-clock fall.
  always_ff @(posedge CLK or posedge power_on_reset) begin
    if (power_on_reset) begin
      r_state <= ST_ASSERT;
      r_reset <= 1'b1;
    end else begin
      case (r_state)
        ST_ASSERT: r_state <= ST_ALIGN;
        ST_COUNT:  r_state <= ST_ALIGN;
        ST_ALIGN: begin
          if (w_wrap) begin
            r_state <= ST_RUN;
            r_reset <= 1'b0;
          end
        end
        ST_RUN:  r_reset <= 1'b0;
        default: r_state <= ST_ASSERT;
      endcase
    end
  end
`endif

  assign clk      = r_clk;
  assign clk_rise = r_clk_rise;
  assign reset    = r_reset;
  assign cur_div  = r_cur_div;

endmodule

// File: tb/tb_clkrstgen.sv
// Testbench for clkrstgen.
// A period-level reference model expands every divided-clock period into per-edge
// expectations and feeds them to a scoreboard queue. A monitor process pops an
// expectation on each CLK falling edge and compares it with the DUT outputs.
module tb_clkrstgen;

  localparam int unsigned DIVBITS     = 4;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned RSTCYCLES   = 16;
`ifdef CLKRSTGEN_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int FIRST_RISE = (DEFAULT_DIV + 1) / 2;
  localparam int FALL_EDGE  = STRETCH ? int'(DEFAULT_DIV * RSTCYCLES) : int'(DEFAULT_DIV);

  logic               CLK = 1'b0;
  logic               power_on_reset;
  logic [DIVBITS-1:0] div;
  logic               div_load;
  logic               clk;
  logic               clk_rise;
  logic               reset;
  logic [DIVBITS-1:0] cur_div;

  int n_vec = 0;
  int n_err = 0;

  clkrstgen #(
    .DIVBITS    (DIVBITS),
    .DEFAULT_DIV(DEFAULT_DIV),
    .RSTCYCLES  (RSTCYCLES)
  ) dut (
    .CLK           (CLK),
    .power_on_reset(power_on_reset),
    .div           (div),
    .div_load      (div_load),
    .clk           (clk),
    .clk_rise      (clk_rise),
    .reset         (reset),
    .cur_div       (cur_div)
  );

  always #5 CLK = ~CLK;

  // One entry per CLK edge of a period: the level after the edge, and whether it is the rise or the wrap.
  typedef struct packed {
    logic c;
    logic r;
    logic w;
  } ent_t;

  typedef struct packed {
    logic               c;
    logic               r;
    logic               rs;
    logic [DIVBITS-1:0] cd;
  } exp_t;

  ent_t sched[$];
  exp_t sb_q[$];
  int   m_cur   = DEFAULT_DIV;
  int   m_pend  = DEFAULT_DIV;
  int   m_rises = 0;
  bit   m_hold  = 1'b1;
  bit   m_rst   = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divisor d: clk is low for ceil(d/2) edges and high for floor(d/2) edges.
  // It rises at edge ceil(d/2) of the period and falls at edge d, the wrap.
  task automatic fill_period(input int d);
    ent_t x;
    for (int j = 1; j <= d; j++) begin
      x.c = (j >= (d + 1) / 2) && (j < d);
      x.r = (j == (d + 1) / 2);
      x.w = (j == d);
      sched.push_back(x);
    end
  endtask

  // Reference model: one expectation per CLK edge while out of reset.
  always @(posedge CLK or posedge power_on_reset) begin
    exp_t e;
    ent_t s;
    int   old_pend;
    if (power_on_reset) begin
      m_cur   = DEFAULT_DIV;
      m_pend  = DEFAULT_DIV;
      m_rises = 0;
      m_hold  = 1'b1;
      m_rst   = 1'b1;
      sched.delete();
      sb_q.delete();
    end else begin
      old_pend = m_pend;
      if (div_load) m_pend = (int'(div) < 2) ? 2 : int'(div);
      if (m_hold) begin
        m_hold = 1'b0;
        fill_period(m_cur);
        e.c  = 1'b0;
        e.r  = 1'b0;
      end else begin
        s = sched.pop_front();
        if (s.r) m_rises++;
        if (s.w) begin
          if (!STRETCH || m_rises >= int'(RSTCYCLES)) m_rst = 1'b0;
          m_cur = old_pend;
          fill_period(m_cur);
        end
        e.c = s.c;
        e.r = s.r;
      end
      e.rs = m_rst;
      e.cd = DIVBITS'(m_cur);
      sb_q.push_back(e);
      if (sb_q.size() > 2) begin
        n_err++;
        $display("FAIL sb_backlog: got %0d queued expected <=2", sb_q.size());
      end
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if ({clk, clk_rise, reset, cur_div} !== {e.c, e.r, e.rs, e.cd}) begin
        n_err++;
        $display("FAIL cycle t=%0t: got clk=%b rise=%b reset=%b cur_div=%0d expected clk=%b rise=%b reset=%b cur_div=%0d",
                 $time, clk, clk_rise, reset, cur_div, e.c, e.r, e.rs, e.cd);
      end
    end
  end

  task automatic check_rst_vals(input string tag);
    #1;
    chk({tag, "_clk"},     int'(clk),      0);
    chk({tag, "_rise"},    int'(clk_rise), 0);
    chk({tag, "_reset"},   int'(reset),    1);
    chk({tag, "_cur_div"}, int'(cur_div),  DEFAULT_DIV);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input int v);
    div      = DIVBITS'(v);
    div_load = 1'b1;
    @(negedge CLK);
    div_load = 1'b0;
  endtask

  // Release at a falling edge, then measure the edges of the first clk rise and the reset fall.
  task automatic release_and_measure(input string tag);
    int first_rise;
    int fall;
    first_rise = -1;
    fall       = -1;
    power_on_reset = 1'b0;
    for (int e = 0; e < FALL_EDGE + 8; e++) begin
      @(negedge CLK);
      if (first_rise < 0 && clk === 1'b1) first_rise = e;
      if (fall < 0 && reset === 1'b0) fall = e;
    end
    chk({tag, "_first_rise_edge"}, first_rise, FIRST_RISE);
    chk({tag, "_reset_fall_edge"}, fall, FALL_EDGE);
  endtask

  task automatic wait_clk_high();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (clk === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("wait_clk_high_timeout", 0, 1);
  endtask

  task automatic load_on_wrap(input int v);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (!m_hold && sched.size() == 1) found = 1'b1;
    end
    if (!found) chk("wrap_align_timeout", 0, 1);
    load(v);
  endtask

  initial begin
    power_on_reset = 1'b1;
    div            = '0;
    div_load       = 1'b0;
    repeat (3) @(negedge CLK);
    check_rst_vals("por");
    release_and_measure("rel1");
    run(10);

    run(1);
    load(3);
    run(30);

    load(0);
    load(1);
    run(20);

    load(4);
    run(20);
    load_on_wrap(6);
    run(40);

    wait_clk_high();
    #2 power_on_reset = 1'b1;
    check_rst_vals("por_clkhigh");
    @(negedge CLK);
    release_and_measure("rel2");

    power_on_reset = 1'b1;
    @(negedge CLK);
    power_on_reset = 1'b0;
    run(20);
    #2 power_on_reset = 1'b1;
    check_rst_vals("por_count");
    @(negedge CLK);
    release_and_measure("rel3");

    load(15);
    run(60);

    for (int i = 0; i < 3000; i++) begin
      div      = DIVBITS'($urandom);
      div_load = ($urandom_range(7) == 0);
      if ($urandom_range(399) == 0) begin
        div_load = 1'b0;
        @(negedge CLK);
        #2 power_on_reset = 1'b1;
        check_rst_vals("rand_por");
        repeat ($urandom_range(2) + 1) @(negedge CLK);
        power_on_reset = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
    div_load = 1'b0;
    run(3);
    chk("sb_drained", (sb_q.size() <= 1) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
